// File: rtl/mul8_pkg.sv
// Shared definitions for the 8x8 multiply-accumulate datapath.
package mul8_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;
endpackage

// File: rtl/mul8_lrtl.sv
// Combinational unsigned 8x8 multiplier.
module mul8_lrtl
  import mul8_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);
  assign p = PROD_W'(a) * PROD_W'(b);
endmodule

// File: rtl/mac8_acc.sv
// Framed streaming multiply-accumulate: one registered operand stage feeding
// mul8_lrtl, accumulation over a frame, one held result per frame.
//   state | meaning
//   ACCUM | accepting beats, accumulating products
//   HOLD  | frame result valid, waiting for consumer
module mac8_acc
  import mul8_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  mac_state_e       state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic [OP_W-1:0]  s1_a_q, s1_a_d;
  logic [OP_W-1:0]  s1_b_q, s1_b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_ext;
  logic              carry;
  logic [CNT_W-1:0]  cnt_inc;
  logic              xfer;

  mul8_lrtl u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (prod)
  );

  // A last beat sitting in stage 1 blocks the next frame until it closes.
  assign in_ready = (state_q == ACCUM) && !(s1_valid_q && s1_last_q);
  assign xfer     = in_valid && in_ready;
  assign sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(prod);
  assign carry    = sum_ext[ACC_W];
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = xfer;
    s1_last_d   = s1_last_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (xfer) begin
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_last_d = in_last;
    end

    if (s1_valid_q && s1_last_q) begin
      out_sum_d   = sum_ext[ACC_W-1:0];
      out_count_d = cnt_inc;
      out_ovf_d   = ovf_q | carry;
      out_valid_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      state_d     = HOLD;
    end else if (s1_valid_q) begin
      acc_d = sum_ext[ACC_W-1:0];
      cnt_d = cnt_inc;
      ovf_d = ovf_q | carry;
    end

    if (state_q == HOLD && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac8_acc.sv
// Bench for mac8_acc: a 24-bit and a 16-bit accumulator instance share one
// input stream; results are compared against an arithmetic frame model.
module tb_mac8_acc;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;

  logic        ir24, ov24, of24;
  logic [23:0] sum24;
  logic [7:0]  cnt24;
  logic        ir16, ov16, of16;
  logic [15:0] sum16;
  logic [7:0]  cnt16;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned fa[16];
  int unsigned fb[16];

  logic [23:0] cap_sum24;
  logic [15:0] cap_sum16;
  logic [7:0]  cap_cnt24;
  logic        cap_of24, cap_of16;

  always #5 clk = ~clk;

  mac8_acc #(.ACC_W(24), .CNT_W(8)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir24),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov24), .out_ready(out_ready),
    .out_sum(sum24), .out_count(cnt24), .out_ovf(of24)
  );

  mac8_acc #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(ov16), .out_ready(out_ready),
    .out_sum(sum16), .out_count(cnt16), .out_ovf(of16)
  );

  // Frame result from plain arithmetic: the carry fires at least once
  // exactly when the true sum reaches 2^w, since every product is non-negative.
  function automatic void model(input int off, input int n, input int w,
                                output longint sum, output int cnt, output bit ovf);
    longint total = 0;
    longint m = longint'(1) << w;
    for (int i = 0; i < n; i++) total += longint'(fa[off+i]) * longint'(fb[off+i]);
    sum = total % m;
    ovf = (total >= m);
    cnt = (n > 255) ? 255 : n;
  endfunction

  task automatic send_beat(input int unsigned a, input int unsigned b, input bit last);
    int g = 0;
    in_a = 8'(a); in_b = 8'(b); in_last = last; in_valid = 1'b1;
    while (!ir24 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    n_checks++;
    if (!ir24) begin
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", ir24);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Sends fa/fb[0..n-1], checks latency and the result, then consumes it.
  task automatic run_frame(input int n, input string name);
    longint es24, es16; int ec; bit eo24, eo16;
    model(0, n, 24, es24, ec, eo24);
    model(0, n, 16, es16, ec, eo16);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) send_beat(fa[i], fb[i], i == n-1);
    n_checks++;
    if (ov24 !== 1'b0 || ir24 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: out_valid=%0b in_ready=%0b required 0 0", name, ov24, ir24);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov24 !== 1'b1 || ov16 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid=%0b/%0b required 1/1", name, ov24, ov16);
    end
    n_checks++;
    if (sum24 !== 24'(es24) || cnt24 !== 8'(ec) || of24 !== eo24) begin
      n_fail++;
      $display("FAIL %s_res24: sum=%0d cnt=%0d ovf=%0b required %0d %0d %0b",
               name, sum24, cnt24, of24, es24, ec, eo24);
    end
    n_checks++;
    if (sum16 !== 16'(es16) || cnt16 !== 8'(ec) || of16 !== eo16) begin
      n_fail++;
      $display("FAIL %s_res16: sum=%0d cnt=%0d ovf=%0b required %0d %0d %0b",
               name, sum16, cnt16, of16, es16, ec, eo16);
    end
    cap_sum24 = sum24; cap_sum16 = sum16; cap_cnt24 = cnt24;
    cap_of24 = of24; cap_of16 = of16;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (ov24 !== 1'b0 || ir24 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0 1", name, ov24, ir24);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (ov24 !== 0 || sum24 !== 0 || cnt24 !== 0 || of24 !== 0 || ir24 !== 1 ||
        ov16 !== 0 || sum16 !== 0 || cnt16 !== 0 || of16 !== 0 || ir16 !== 1) begin
      n_fail++;
      $display("FAIL reset_state: v=%0b s=%0d c=%0d o=%0b rdy=%0b required 0 0 0 0 1",
               ov24, sum24, cnt24, of24, ir24);
    end
  endtask

  task automatic test_basic();
    fa[0] = 3; fb[0] = 4; fa[1] = 5; fb[1] = 6; fa[2] = 255; fb[2] = 255;
    run_frame(3, "basic");
    n_checks++;
    if (cap_sum24 !== 24'd65067 || cap_cnt24 !== 8'd3 || cap_of24 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_const: sum=%0d cnt=%0d ovf=%0b required 65067 3 0",
               cap_sum24, cap_cnt24, cap_of24);
    end
  endtask

  task automatic test_single_beat();
    fa[0] = 0; fb[0] = 0;
    run_frame(1, "single0");
    n_checks++;
    if (cap_sum24 !== 24'd0 || cap_cnt24 !== 8'd1) begin
      n_fail++;
      $display("FAIL single0_const: sum=%0d cnt=%0d required 0 1", cap_sum24, cap_cnt24);
    end
    fa[0] = 1; fb[0] = 1;
    run_frame(1, "single1");
    n_checks++;
    if (cap_sum24 !== 24'd1 || cap_cnt24 !== 8'd1) begin
      n_fail++;
      $display("FAIL single1_const: sum=%0d cnt=%0d required 1 1", cap_sum24, cap_cnt24);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      int n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        fa[i] = $urandom_range(0, 255); fb[i] = $urandom_range(0, 255);
      end
      run_frame(n, "random");
    end
  endtask

  task automatic test_backpressure();
    longint es; int ec; bit eo;
    logic [23:0] held;
    fa[0] = $urandom_range(0, 255); fb[0] = $urandom_range(0, 255);
    fa[1] = $urandom_range(0, 255); fb[1] = $urandom_range(0, 255);
    model(0, 2, 24, es, ec, eo);
    out_ready = 1'b0;
    send_beat(fa[0], fb[0], 1'b0);
    send_beat(fa[1], fb[1], 1'b1);
    @(posedge clk); #1;
    held = sum24;
    n_checks++;
    if (held !== 24'(es)) begin
      n_fail++;
      $display("FAIL bp_sum: sum=%0d required %0d", held, es);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov24 !== 1'b1 || sum24 !== held || ir24 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: v=%0b sum=%0d rdy=%0b required 1 %0d 0", ov24, sum24, ir24, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (ir24 !== 1'b1 || ov24 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: rdy=%0b v=%0b required 1 0", ir24, ov24);
    end
  endtask

  task automatic test_overflow();
    fa[0] = 255; fb[0] = 255; fa[1] = 255; fb[1] = 255;
    run_frame(2, "ovf");
    n_checks++;
    if (cap_sum16 !== 16'd64514 || cap_of16 !== 1'b1 || cap_of24 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_const: sum16=%0d ovf16=%0b ovf24=%0b required 64514 1 0",
               cap_sum16, cap_of16, cap_of24);
    end
    fa[0] = 2; fb[0] = 2;
    run_frame(1, "ovf_clear");
    n_checks++;
    if (cap_sum16 !== 16'd4 || cap_of16 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear_const: sum16=%0d ovf16=%0b required 4 0", cap_sum16, cap_of16);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_beat(10, 10, 1'b0);
    send_beat(20, 20, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ov24 !== 0 || sum24 !== 0 || cnt24 !== 0 || of24 !== 0 || ir24 !== 1 ||
        sum16 !== 0 || ir16 !== 1) begin
      n_fail++;
      $display("FAIL midrst_state: v=%0b s=%0d c=%0d o=%0b rdy=%0b required 0 0 0 0 1",
               ov24, sum24, cnt24, of24, ir24);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    fa[0] = 7; fb[0] = 9;
    run_frame(1, "midrst");
    n_checks++;
    if (cap_sum24 !== 24'd63 || cap_cnt24 !== 8'd1) begin
      n_fail++;
      $display("FAIL midrst_const: sum=%0d cnt=%0d required 63 1", cap_sum24, cap_cnt24);
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[8];
    int idx = 0, fidx = 0, guard = 0, tail = 0;
    bit take;
    longint es; int ec; bit eo;
    for (int i = 0; i < 8; i++) begin
      fa[i] = $urandom_range(0, 255); fb[i] = $urandom_range(0, 255);
    end
    out_ready = 1'b1;
    while ((idx < 8 || fidx < 4) && guard < 200) begin
      if (idx < 8) begin
        in_a = 8'(fa[idx]); in_b = 8'(fb[idx]); in_last = (idx % 2 == 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
        tail++;
      end
      take = ir24 && in_valid;
      @(posedge clk); #1;
      guard++;
      if (take) begin
        acc_cyc[idx] = guard;
        idx++;
      end
      if (ov24 === 1'b1 && fidx < 4) begin
        model(2*fidx, 2, 24, es, ec, eo);
        n_checks++;
        if (sum24 !== 24'(es) || cnt24 !== 8'd2 || of24 !== eo) begin
          n_fail++;
          $display("FAIL b2b_frame%0d: sum=%0d cnt=%0d ovf=%0b required %0d 2 %0b",
                   fidx, sum24, cnt24, of24, es, eo);
        end
        fidx++;
      end
      if (tail > 6) break;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (idx != 8 || fidx != 4) begin
      n_fail++;
      $display("FAIL b2b_progress: beats=%0d frames=%0d required 8 4", idx, fidx);
    end
    for (int k = 0; k < 4 && idx == 8; k++) begin
      n_checks++;
      if (acc_cyc[2*k+1] - acc_cyc[2*k] != 1) begin
        n_fail++;
        $display("FAIL b2b_inframe%0d: spacing=%0d required 1", k, acc_cyc[2*k+1] - acc_cyc[2*k]);
      end
      if (k > 0) begin
        n_checks++;
        // idle cycles between the previous frame's last beat and this frame's first
        if (acc_cyc[2*k] - acc_cyc[2*k-1] - 1 != 2) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: idle=%0d required 2", k, acc_cyc[2*k] - acc_cyc[2*k-1] - 1);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_single_beat();
    test_random_frames();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac8_acc.md
# mac8_acc

Streaming multiply-accumulate stage wrapped around the 8x8 multiplier `mul8_lrtl`. It accepts a framed stream of unsigned 8-bit operand pairs with a valid/ready handshake and registers each pair into the multiplier. It accumulates the 16-bit products over the frame and presents one sum per frame on a valid/ready output. It sits in the dot-product datapath, between the operand fetch logic and the result consumer.

## Interface
- `ACC_W`, default 24: accumulator and result width; must be at least 16.
- `CNT_W`, default 8: width of the beat counter and of `out_count`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_a` input 8: unsigned multiplicand.
- `in_b` input 8: unsigned multiplier.
- `in_last` input 1: final beat of the frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output ACC_W: sum of the frame's products, modulo 2^ACC_W.
- `out_count` output CNT_W: beats in the frame, saturating at all-ones.
- `out_ovf` output 1: the accumulator carried out of bit ACC_W-1 at least once in the frame.

## Operation
- **Beat transfer.** A beat transfers when `in_valid && in_ready` at a rising edge.
- **Stage 1 (operand register).** On a transfer:
  - `s1_a`, `s1_b` and `s1_last` load from the inputs.
  - `s1_valid` is set to 1.
  - With no transfer, `s1_valid` clears to 0.
- **Multiplier.** `mul8_lrtl` is combinational. Its inputs are `s1_a`/`s1_b`, giving product `p` of 16 bits, zero-extended to ACC_W bits.
- **Stage 2 (accumulate).** When `s1_valid` is 1:
  - `acc <= acc + p`.
  - `cnt <= cnt + 1`, saturating at all-ones.
  - `ovf` is set sticky on a carry out.
- **Frame close.** When `s1_valid && s1_last`:
  - Instead of the stage-2 update, `out_sum <= acc + p`, `out_count <= cnt + 1` (saturating) and `out_ovf <= ovf | carry`.
  - `out_valid <= 1`.
  - `acc`, `cnt` and `ovf` clear to 0.
  - FSM moves ACCUM -> HOLD.
- **FSM.**
  - ACCUM: accept beats.
  - HOLD: result pending.
  - HOLD -> ACCUM on `out_valid && out_ready`; `out_valid` clears on the same edge.
- **Ready rule.** `in_ready = (state == ACCUM) && !(s1_valid && s1_last)`. No beat of the next frame enters while a last beat is in stage 1 or a result is held.
- **Output stability.** `out_sum`, `out_count` and `out_ovf` hold stable while `out_valid && !out_ready`.
- **Reset.** Asynchronous and active-high. Every register clears:
  - `s1_*`, `acc`, `cnt` and `ovf` = 0.
  - State = ACCUM.
  - `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_ovf` = 0.
  - `in_ready` is therefore 1 after reset.
  - A partial frame is discarded, and so is a held, unconsumed result.
- **Arithmetic.** All operands are unsigned. The sum wraps modulo 2^ACC_W, with the wrap reported via `out_ovf`.

## Timing
- **Throughput.** One beat per cycle within a frame.
- **Latency.** With last beat accepted at edge t, `out_valid` is 1 after edge t+1. That is 2 edges from acceptance, 1 cycle after stage 1.
- **Gap between frames.**
  - `in_ready` is 0 during the cycle after the last beat is accepted (stage 1 holds last).
  - It stays 0 for every cycle in HOLD.
  - With `out_ready` tied high, the minimum gap between the last beat of one frame and the first beat of the next is 2 cycles.
- **Simultaneous events.**
  - An output handshake and a new input cannot coincide: `in_ready` is 0 in HOLD.
  - `in_ready` returns to 1 on the cycle after the output handshake edge.
- **Handshake rules.**
  - `in_valid` without `in_ready` does not consume the beat.
  - The source holds the beat until it transfers; the block does not check this.

## Structure
- Shared package `mul8_pkg`:
  - `OP_W` = 8 and `PROD_W` = 16.
  - FSM state typedef {ACCUM, HOLD}.
- Sub-module: a single instance of the existing `mul8_lrtl` on the stage-1 registers. No further hierarchy.

## Test plan
- **Basic frame.** Frame (3,4), (5,6), (255,255 last) -> `out_sum` = 65067, `out_count` = 3, `out_ovf` = 0, `out_valid` 2 edges after the last beat.
- **Single-beat frame.** Single beat (0,0 last) -> `out_sum` = 0, `out_count` = 1. Then (1,1 last) -> `out_sum` = 1, proving `acc` cleared.
- **Back-pressure.** `out_ready` = 0 for 5 cycles after a result -> `out_valid` and `out_sum` held stable and `in_ready` = 0 throughout. Raise `out_ready` -> `in_ready` = 1 on the next cycle.
- **Overflow.** With ACC_W = 16, beats (255,255), (255,255 last) -> `out_sum` = 64514, `out_ovf` = 1. The next frame (2,2 last) -> `out_ovf` = 0.
- **Reset mid-frame.** Assert `rst` after two beats of a frame -> all outputs 0 immediately and `in_ready` = 1. A new frame (7,9 last) -> `out_sum` = 63, `out_count` = 1.
- **Back-to-back frames.** `in_valid` and `out_ready` held high, 4 frames of 2 beats, random operands -> sums match the reference model, and accepted-beat gaps are exactly 2 cycles between frames.
